// File: rtl/dvp_pixel_tx.sv
// DVP pixel transmitter: turns an RGB565 pixel stream into DVP byte-lane video
// with vsync/href/hsync framing. pclk runs at clk/2, and every other DVP output
// is registered on the clk edge where pclk falls (a "tick").
module dvp_pixel_tx #(
  parameter int DVP_DATA_W  = 8,
  parameter int RGB_PXL_W   = 16,
  parameter int H_ACT       = 640,
  parameter int H_BLANK     = 144,
  parameter int HSYNC_LEN   = 16,
  parameter int V_ACT       = 480,
  parameter int VSYNC_LINES = 3,
  parameter int VBP_LINES   = 17,
  parameter int VFP_LINES   = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_start_i,
  input  logic [RGB_PXL_W-1:0]  rgb_pxl_i,
  input  logic                  rgb_pxl_vld_i,
  output logic                  rgb_pxl_rdy_o,
  output logic                  dvp_pclk_o,
  output logic                  dvp_vsync_o,
  output logic                  dvp_href_o,
  output logic                  dvp_hsync_o,
  output logic [DVP_DATA_W-1:0] dvp_d_o,
  output logic                  frame_done_o,
  output logic                  underrun_o
);

  localparam int LINE_LEN = 2 * H_ACT + H_BLANK;
  localparam int POS_W    = $clog2(LINE_LEN + 1);
  localparam int LMAX_A   = (VSYNC_LINES > VBP_LINES) ? VSYNC_LINES : VBP_LINES;
  localparam int LMAX_B   = (V_ACT > VFP_LINES) ? V_ACT : VFP_LINES;
  localparam int LINE_MAX = (LMAX_A > LMAX_B) ? LMAX_A : LMAX_B;
  localparam int LINE_W   = $clog2(LINE_MAX + 1);

  localparam logic [POS_W-1:0] POS_LAST  = POS_W'(LINE_LEN - 1);
  localparam logic [POS_W-1:0] HREF_END  = POS_W'(2 * H_ACT);
  localparam logic [POS_W-1:0] HSYNC_END = POS_W'(2 * H_ACT + HSYNC_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_VBP,
    S_ACTIVE,
    S_VFP
  } state_t;

  state_t                 state_reg, state_next;
  logic [POS_W-1:0]       pos_reg, pos_next;
  logic [LINE_W-1:0]      line_reg, line_next, line_last;
  logic                   phase_reg;
  logic                   frame_end;

  logic [RGB_PXL_W-1:0]   hold_reg;
  logic                   full_reg;
  logic                   slot_ok_reg, slot_ok_next;
  logic                   vsync_reg, vsync_next;
  logic                   href_reg, href_next;
  logic                   hsync_reg, hsync_next;
  logic [DVP_DATA_W-1:0]  d_reg, d_next;
  logic                   frame_done_reg;
  logic                   underrun_reg;
  logic                   underrun_set;
  logic                   free_now;
  logic                   load_now;
  logic                   tick;

  // pclk is high in phase 1; the edge leaving phase 1 is the tick
  assign tick       = phase_reg;
  assign dvp_pclk_o = phase_reg;

  // Holding register accepts a new pixel when empty, or in the same clk the
  // current one leaves with its low byte, so back-to-back pixels never stall.
  assign rgb_pxl_rdy_o = ~full_reg | free_now;
  assign load_now      = rgb_pxl_vld_i & rgb_pxl_rdy_o;

  // State register: phase toggles every clk, timing state moves on ticks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_reg <= 1'b0;
      state_reg <= S_IDLE;
      pos_reg   <= '0;
      line_reg  <= '0;
    end else begin
      phase_reg <= ~phase_reg;
      if (tick) begin
        state_reg <= state_next;
        pos_reg   <= pos_next;
        line_reg  <= line_next;
      end
    end
  end

  // Next-state logic: pixel position within the line, line within the region
  always_comb begin
    state_next = state_reg;
    pos_next   = pos_reg;
    line_next  = line_reg;
    frame_end  = 1'b0;
    case (state_reg)
      S_VSYNC:  line_last = LINE_W'(VSYNC_LINES - 1);
      S_VBP:    line_last = LINE_W'(VBP_LINES - 1);
      S_ACTIVE: line_last = LINE_W'(V_ACT - 1);
      S_VFP:    line_last = LINE_W'(VFP_LINES - 1);
      default:  line_last = '0;
    endcase
    if (state_reg == S_IDLE) begin
      if (cfg_start_i) begin
        state_next = S_VSYNC;
        pos_next   = '0;
        line_next  = '0;
      end
    end else if (pos_reg == POS_LAST) begin
      pos_next = '0;
      if (line_reg == line_last) begin
        line_next = '0;
        case (state_reg)
          S_VSYNC:  state_next = S_VBP;
          S_VBP:    state_next = S_ACTIVE;
          S_ACTIVE: state_next = S_VFP;
          default: begin
            frame_end  = 1'b1;
            state_next = cfg_start_i ? S_VSYNC : S_IDLE;
          end
        endcase
      end else begin
        line_next = line_reg + 1'b1;
      end
    end else begin
      pos_next = pos_reg + 1'b1;
    end
  end

  // Output logic: framing and byte lane for the position entered at this tick
  always_comb begin
    vsync_next   = (state_next == S_VSYNC);
    href_next    = (state_next == S_ACTIVE) && (pos_next < HREF_END);
    hsync_next   = (state_next != S_IDLE) && (pos_next >= HREF_END) &&
                   (pos_next < HSYNC_END);
    d_next       = '0;
    slot_ok_next = slot_ok_reg;
    underrun_set = 1'b0;
    free_now     = 1'b0;
    if (href_next) begin
      if (!pos_next[0]) begin
        // high byte opens a pixel slot; an empty register makes it a zero slot
        slot_ok_next = full_reg;
        underrun_set = ~full_reg;
        d_next       = full_reg ? hold_reg[RGB_PXL_W-1 -: DVP_DATA_W] : '0;
      end else begin
        d_next   = slot_ok_reg ? hold_reg[DVP_DATA_W-1:0] : '0;
        free_now = tick & slot_ok_reg;
      end
    end
  end

  // DVP output registers, updated only on ticks; frame_done is a one-clk pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_reg      <= 1'b0;
      href_reg       <= 1'b0;
      hsync_reg      <= 1'b0;
      d_reg          <= '0;
      slot_ok_reg    <= 1'b0;
      frame_done_reg <= 1'b0;
      underrun_reg   <= 1'b0;
    end else begin
      frame_done_reg <= tick & frame_end;
      if (tick) begin
        vsync_reg   <= vsync_next;
        href_reg    <= href_next;
        hsync_reg   <= hsync_next;
        d_reg       <= d_next;
        slot_ok_reg <= slot_ok_next;
        if (state_reg == S_IDLE && cfg_start_i) begin
          underrun_reg <= 1'b0;
        end else if (underrun_set) begin
          underrun_reg <= 1'b1;
        end
      end
    end
  end

  // One-entry pixel holding register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_reg <= 1'b0;
      hold_reg <= '0;
    end else begin
      if (load_now) begin
        hold_reg <= rgb_pxl_i;
        full_reg <= 1'b1;
      end else if (free_now) begin
        full_reg <= 1'b0;
      end
    end
  end

  assign dvp_vsync_o  = vsync_reg;
  assign dvp_href_o   = href_reg;
  assign dvp_hsync_o  = hsync_reg;
  assign dvp_d_o      = d_reg;
  assign frame_done_o = frame_done_reg;
  assign underrun_o   = underrun_reg;

endmodule

// File: tb/tb_dvp_pixel_tx.sv
// Scoreboard bench for dvp_pixel_tx with a small 14-tick x 5-line frame.
module tb_dvp_pixel_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cfg_start_i = 1'b0;
  logic [15:0] rgb_pxl_i = '0;
  logic        rgb_pxl_vld_i = 1'b0;
  logic        rgb_pxl_rdy_o;
  logic        dvp_pclk_o, dvp_vsync_o, dvp_href_o, dvp_hsync_o;
  logic [7:0]  dvp_d_o;
  logic        frame_done_o, underrun_o;

  int checks = 0;
  int failures = 0;
  int fd_seen = 0;
  logic [7:0] exp_q[$];
  bit drv_en = 0;
  int pix_idx = 0;
  logic [15:0] pix_tab [8] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0,
                               16'h0F1E, 16'h2D3C, 16'h4B5A, 16'h6978};

  dvp_pixel_tx #(
    .DVP_DATA_W(8), .RGB_PXL_W(16), .H_ACT(4), .H_BLANK(6), .HSYNC_LEN(2),
    .V_ACT(2), .VSYNC_LINES(1), .VBP_LINES(1), .VFP_LINES(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start_i(cfg_start_i),
    .rgb_pxl_i(rgb_pxl_i), .rgb_pxl_vld_i(rgb_pxl_vld_i),
    .rgb_pxl_rdy_o(rgb_pxl_rdy_o),
    .dvp_pclk_o(dvp_pclk_o), .dvp_vsync_o(dvp_vsync_o),
    .dvp_href_o(dvp_href_o), .dvp_hsync_o(dvp_hsync_o), .dvp_d_o(dvp_d_o),
    .frame_done_o(frame_done_o), .underrun_o(underrun_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // sel: 0 vsync high, 1 href high, 2 frame_done pulse
  task automatic wait_for(input int sel, input int budget, input string name);
    bit hit = 0;
    for (int n = 0; n < budget && !hit; n++) begin
      @(posedge clk); #1;
      case (sel)
        0: hit = dvp_vsync_o;
        1: hit = dvp_href_o;
        default: hit = frame_done_o;
      endcase
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL wait_%s: not seen within %0d clk", name, budget);
    end else begin
      $display("ok   wait_%s", name);
    end
  endtask

  // Driver: offers pixels on clk falling edges; an accepted pixel pushes its
  // two expected bytes (high first). rdy only moves on clk rising edges.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n || !drv_en) begin
        rgb_pxl_vld_i = 1'b0;
      end else begin
        rgb_pxl_vld_i = 1'b1;
        rgb_pxl_i = pix_tab[pix_idx % 8];
        if (rgb_pxl_rdy_o) begin
          exp_q.push_back(rgb_pxl_i[15:8]);
          exp_q.push_back(rgb_pxl_i[7:0]);
          pix_idx++;
        end
      end
    end
  end

  // Monitor: edge alignment every clk, framing and scoreboard on every tick
  logic        prev_pclk = 1'b0;
  logic [10:0] prev_outs = '0;
  bit          in_frame = 0;
  int          ft = 0;
  always @(posedge clk) begin
    logic [10:0] outs;
    bit fell, exp_fd, exp_vs, exp_hr, exp_hs;
    int lp;
    #1;
    outs = {dvp_vsync_o, dvp_href_o, dvp_hsync_o, dvp_d_o};
    if (!rst_n) begin
      in_frame = 0;
      prev_pclk = 1'b0;
      prev_outs = '0;
    end else begin
      checks++;
      if (dvp_pclk_o == prev_pclk) begin
        failures++;
        $display("FAIL pclk_toggle: got %0b expected %0b", dvp_pclk_o, ~prev_pclk);
      end
      fell = prev_pclk && !dvp_pclk_o;
      if (outs != prev_outs) begin
        checks++;
        if (!fell) begin
          failures++;
          $display("FAIL edge_align: outputs %0h->%0h without pclk fall", prev_outs, outs);
        end
      end
      if (frame_done_o) fd_seen++;
      if (fell) begin
        exp_fd = 0;
        if (in_frame) begin
          ft++;
          if (ft == 70) begin
            exp_fd = 1;
            in_frame = 0;
          end
        end
        if (dvp_vsync_o && !prev_outs[10]) begin
          in_frame = 1;
          ft = 0;
        end
        lp = ft % 14;
        exp_vs = in_frame && ft < 14;
        exp_hr = in_frame && ft >= 28 && ft < 56 && lp < 8;
        exp_hs = in_frame && lp >= 8 && lp < 10;
        checks += 4;
        if (dvp_vsync_o != exp_vs) begin
          failures++;
          $display("FAIL vsync t=%0d: got %0b expected %0b", ft, dvp_vsync_o, exp_vs);
        end
        if (dvp_href_o != exp_hr) begin
          failures++;
          $display("FAIL href t=%0d: got %0b expected %0b", ft, dvp_href_o, exp_hr);
        end
        if (dvp_hsync_o != exp_hs) begin
          failures++;
          $display("FAIL hsync t=%0d: got %0b expected %0b", ft, dvp_hsync_o, exp_hs);
        end
        if (frame_done_o != exp_fd) begin
          failures++;
          $display("FAIL frame_done t=%0d: got %0b expected %0b", ft, frame_done_o, exp_fd);
        end
        checks++;
        if (dvp_href_o) begin
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL data_underflow: got %02h with no expected byte", dvp_d_o);
          end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (dvp_d_o != e) begin
              failures++;
              $display("FAIL data t=%0d: got %02h expected %02h", ft, dvp_d_o, e);
            end else begin
              $display("byte t=%0d d=%02h", ft, dvp_d_o);
            end
          end
        end else if (dvp_d_o != 8'h00) begin
          failures++;
          $display("FAIL d_idle t=%0d: got %02h expected 00", ft, dvp_d_o);
        end
      end
      prev_pclk = dvp_pclk_o;
      prev_outs = outs;
    end
  end

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pclk", 32'(dvp_pclk_o), 0);
    chk("rst_vsync", 32'(dvp_vsync_o), 0);
    chk("rst_href", 32'(dvp_href_o), 0);
    chk("rst_hsync", 32'(dvp_hsync_o), 0);
    chk("rst_d", 32'(dvp_d_o), 0);
    chk("rst_fd", 32'(frame_done_o), 0);
    chk("rst_underrun", 32'(underrun_o), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_rdy", 32'(rgb_pxl_rdy_o), 1);

    // Streaming frames with valid always high; stop in active line 0 of frame 2
    drv_en = 1;
    cfg_start_i = 1'b1;
    wait_for(0, 10, "a_vsync1");
    wait_for(2, 200, "a_fd1");
    wait_for(1, 100, "a_href2");
    cfg_start_i = 1'b0;
    wait_for(2, 200, "a_fd2");
    repeat (60) @(posedge clk);
    #1;
    chk("idle_vsync", 32'(dvp_vsync_o), 0);
    chk("idle_href", 32'(dvp_href_o), 0);
    chk("idle_hsync", 32'(dvp_hsync_o), 0);
    chk("idle_d", 32'(dvp_d_o), 0);
    chk("a_fd_count", 32'(fd_seen), 2);
    chk("a_underrun", 32'(underrun_o), 0);
    chk("held_rdy", 32'(rgb_pxl_rdy_o), 0);
    chk("held_q", 32'(exp_q.size()), 2);

    // Reset in the middle of href
    cfg_start_i = 1'b1;
    wait_for(1, 200, "d_href");
    @(posedge clk); #2;
    drv_en = 0;
    rst_n = 1'b0;
    #1;
    chk("mid_pclk", 32'(dvp_pclk_o), 0);
    chk("mid_vsync", 32'(dvp_vsync_o), 0);
    chk("mid_href", 32'(dvp_href_o), 0);
    chk("mid_hsync", 32'(dvp_hsync_o), 0);
    chk("mid_d", 32'(dvp_d_o), 0);
    chk("mid_rdy", 32'(rgb_pxl_rdy_o), 1);
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Frame with no pixels offered: zero bytes and sticky underrun
    wait_for(0, 10, "b_vsync");
    chk("b_start_href", 32'(dvp_href_o), 0);
    chk("b_start_underrun", 32'(underrun_o), 0);
    wait_for(1, 100, "b_href");
    chk("b_underrun_set", 32'(underrun_o), 1);
    cfg_start_i = 1'b0;
    wait_for(2, 200, "b_fd");
    repeat (20) @(posedge clk);
    #1;
    chk("b_underrun_idle", 32'(underrun_o), 1);
    chk("b_q_empty", 32'(exp_q.size()), 0);
    chk("b_rdy", 32'(rgb_pxl_rdy_o), 1);

    // Restart clears underrun; one more streaming frame
    drv_en = 1;
    cfg_start_i = 1'b1;
    wait_for(0, 10, "c_vsync");
    chk("c_underrun_clr", 32'(underrun_o), 0);
    cfg_start_i = 1'b0;
    wait_for(2, 200, "c_fd");
    repeat (20) @(posedge clk);
    #1;
    chk("c_underrun", 32'(underrun_o), 0);
    chk("c_q", 32'(exp_q.size()), 2);
    chk("fd_total", 32'(fd_seen), 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
